instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage of the 8-bit pipeline. Produces the signals latched by the IF/ID pipeline register.
- Owns the PC, boots from the reset vector, and follows branch redirects from EX.
- Honours hazard-unit stalls and takes external interrupts through a vector fetch.
- Reads instruction memory through a combinational 8-bit read port.

Parameters:
- RESET_VEC_ADDR, 8'h00, imem address holding the initial PC.
- INT_VEC_ADDR, 8'h01, imem address holding the interrupt handler PC.
- NOP_INSTR, 8'h00, encoding injected when no valid instruction is issued.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  8  instruction memory read address.
- imem_data  in  8  instruction memory read data, combinational from imem_addr.
- stall  in  1  hazard unit: hold PC.
- redirect_valid  in  1  taken branch/jump resolved downstream.
- redirect_target  in  8  new PC when redirect_valid=1.
- int_req  in  1  level interrupt request.
- int_ack  out  1  one-cycle pulse when the handler vector is loaded.
- int_return_pc  out  8  PC to resume at after the handler.
- if_instruction  out  8  fetched instruction, to IF/ID.
- if_pc  out  8  address of if_instruction.
- if_pc_plus_1  out  8  if_pc+1, mod 256.
- if_valid  out  1  1 = if_instruction is a real fetched instruction.

Behaviour:
- States: BOOT, RUN, INT_VEC.
- Reset (async, while rst=1):
  - state=BOOT, pc=0, saved_pc=0.
  - int_ack=0, int_return_pc=0.
  - if_instruction=NOP_INSTR, if_pc=0, if_pc_plus_1=0, if_valid=0.
- BOOT:
  - imem_addr=RESET_VEC_ADDR; outputs show NOP with if_valid=0.
  - Next edge: pc<=imem_data, go to RUN. Boot latency is 1 cycle after reset release.
- RUN outputs (combinational):
  - imem_addr=pc, if_instruction=imem_data, if_pc=pc, if_pc_plus_1=pc+1 (8-bit wrap), if_valid=1.
- RUN next-PC priority (highest first), evaluated at the edge:
  1. redirect_valid: pc<=redirect_target. Stall and int_req are ignored that cycle. Flushing the IF/ID register is done externally.
  2. int_req and not stall:
     - This cycle the outputs are overridden to if_instruction=NOP_INSTR and if_valid=0; if_pc and if_pc_plus_1 are unchanged.
     - Edge: saved_pc<=pc, go to INT_VEC.
  3. stall: pc holds. Outputs stay stable as long as imem_data is stable.
  4. Otherwise pc<=pc+1. 8'hFF wraps to 8'h00.
- INT_VEC:
  - imem_addr=INT_VEC_ADDR; outputs show NOP with if_valid=0; int_ack=1 this cycle only.
  - Next edge: pc<=imem_data, go to RUN.
  - redirect_valid, stall and int_req are ignored in this state.
- int_return_pc=saved_pc, held until the next interrupt entry.
- int_req held high through the handler re-enters on the first non-stalled RUN cycle. Deasserting it is the requester's job.
- int_req during stall is deferred. No request is latched; it is level-sampled.
- redirect_valid in BOOT or INT_VEC is ignored.
- rst asserted mid-operation: immediate return to reset values, including during INT_VEC.

Decomposition:
- Shared package cpu_pkg holds: state encodings (BOOT=2'd0, RUN=2'd1, INT_VEC=2'd2), NOP_INSTR, RESET_VEC_ADDR, INT_VEC_ADDR. The IF/ID register and the hazard unit use the same NOP constant.
- One natural sub-module: pc_next_sel, a combinational priority mux for redirect/interrupt/stall/increment. The FSM stays in the top module.

Test Plan:
- Boot: imem[0]=8'h20, imem[8'h20]=8'hAA, release rst -> 1 cycle if_valid=0; then if_pc=8'h20, if_instruction=8'hAA, if_pc_plus_1=8'h21.
- Sequential fetch and wrap: PC reaches 8'hFF -> if_pc_plus_1=8'h00; next cycle if_pc=8'h00.
- Stall: stall=1 for 3 cycles at pc=8'h22 -> if_pc stays 8'h22 and imem_addr is constant; release -> if_pc=8'h23 next cycle.
- Redirect and stall together: redirect_valid=1, target=8'h40, stall=1 -> next cycle if_pc=8'h40.
- Interrupt: imem[1]=8'h80, int_req at pc=8'h25 -> that cycle if_valid=0 with NOP; next cycle int_ack=1, int_return_pc=8'h25; then if_pc=8'h80. Repeat with stall=1 -> no entry until stall drops.
- Reset mid-INT_VEC: assert rst during INT_VEC -> outputs are at reset values immediately, int_ack=0, and boot restarts from RESET_VEC_ADDR.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipeline: fetch FSM encoding and the
// reserved imem vector addresses / NOP encoding used by IF, IF/ID and hazard logic.
package cpu_pkg;

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      RUN     = 2'd1,
      INT_VEC = 2'd2
   } fetch_state_t;

   localparam logic [7:0] NOP_INSTR      = 8'h00;
   localparam logic [7:0] RESET_VEC_ADDR = 8'h00;
   localparam logic [7:0] INT_VEC_ADDR   = 8'h01;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux for the RUN state: redirect > interrupt entry > stall > increment.
module pc_next_sel
   import cpu_pkg::*;
(
   input  logic [7:0] pc,
   input  logic       stall,
   input  logic       redirect_valid,
   input  logic [7:0] redirect_target,
   input  logic       int_req,
   output logic [7:0] pc_next,
   output logic       take_int
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      pc_next  = pc + 8'd1;
      take_int = 1'b0;
      if (redirect_valid) begin
         pc_next = redirect_target;
      end else if (int_req && !stall) begin
         // PC is reloaded from the vector in INT_VEC, so holding here is harmless
         take_int = 1'b1;
         pc_next  = pc;
      end else if (stall) begin
         pc_next = pc;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, boots through the reset vector, follows EX redirects,
// honours stalls and enters interrupt handlers through a vector fetch.
module instr_fetch_unit #(
   parameter logic [7:0] RESET_VEC_ADDR = cpu_pkg::RESET_VEC_ADDR,
   parameter logic [7:0] INT_VEC_ADDR   = cpu_pkg::INT_VEC_ADDR,
   parameter logic [7:0] NOP_INSTR      = cpu_pkg::NOP_INSTR
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] imem_addr,
   input  logic [7:0] imem_data,
   input  logic       stall,
   input  logic       redirect_valid,
   input  logic [7:0] redirect_target,
   input  logic       int_req,
   output logic       int_ack,
   output logic [7:0] int_return_pc,
   output logic [7:0] if_instruction,
   output logic [7:0] if_pc,
   output logic [7:0] if_pc_plus_1,
   output logic       if_valid
);

   import cpu_pkg::*;

   fetch_state_t state, state_next;
   logic [7:0]   pc, pc_d;
   logic [7:0]   saved_pc;
   logic         save_pc;
   logic [7:0]   run_pc_next;
   logic         take_int;

   pc_next_sel u_pc_next_sel (
      .pc              (pc),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .int_req         (int_req),
      .pc_next         (run_pc_next),
      .take_int        (take_int)
   );

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so all update together at the edge.
      if (rst) begin
         state    <= BOOT;
         pc       <= 8'h00;
         saved_pc <= 8'h00;
      end else begin
         state <= state_next;
         pc    <= pc_d;
         if (save_pc) begin
            saved_pc <= pc;
         end
      end
   end

   always_comb begin
      state_next     = state;
      pc_d           = pc;
      save_pc        = 1'b0;
      imem_addr      = pc;
      int_ack        = 1'b0;
      if_instruction = NOP_INSTR;
      if_pc          = 8'h00;
      if_pc_plus_1   = 8'h00;
      if_valid       = 1'b0;
      unique case (state)
         BOOT: begin
            imem_addr  = RESET_VEC_ADDR;
            pc_d       = imem_data;
            state_next = RUN;
         end
         RUN: begin
            imem_addr    = pc;
            if_pc        = pc;
            if_pc_plus_1 = pc + 8'd1;
            pc_d         = run_pc_next;
            if (take_int) begin
               save_pc    = 1'b1;
               state_next = INT_VEC;
            end else begin
               if_instruction = imem_data;
               if_valid       = 1'b1;
            end
         end
         INT_VEC: begin
            imem_addr  = INT_VEC_ADDR;
            int_ack    = 1'b1;
            pc_d       = imem_data;
            state_next = RUN;
         end
         default: begin
            state_next = BOOT;
         end
      endcase
   end

   assign int_return_pc = saved_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// control inputs, all compared every cycle against a behavioural fetch model.
module tb_instr_fetch_unit;

   localparam logic [7:0] RST_VEC = 8'h00;
   localparam logic [7:0] INT_VEC = 8'h01;
   localparam logic [7:0] NOP     = 8'h00;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] imem_addr;
   logic [7:0] imem_data;
   logic       stall;
   logic       redirect_valid;
   logic [7:0] redirect_target;
   logic       int_req;
   logic       int_ack;
   logic [7:0] int_return_pc;
   logic [7:0] if_instruction;
   logic [7:0] if_pc;
   logic [7:0] if_pc_plus_1;
   logic       if_valid;

   logic [7:0] imem [256];

   int n_checks = 0;
   int n_fail   = 0;

   // model: mode 0 = booting, 1 = running, 2 = loading the handler vector
   int         m_mode;
   logic [7:0] m_pc;
   logic [7:0] m_saved;

   always #5 clk = ~clk;

   assign imem_data = imem[imem_addr];

   instr_fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .int_req         (int_req),
      .int_ack         (int_ack),
      .int_return_pc   (int_return_pc),
      .if_instruction  (if_instruction),
      .if_pc           (if_pc),
      .if_pc_plus_1    (if_pc_plus_1),
      .if_valid        (if_valid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [7:0] e_addr, e_instr, e_pc, e_pc1;
      logic       e_valid, e_ack;
      bit         enter;
      e_addr = 8'h00; e_instr = NOP; e_pc = 8'h00; e_pc1 = 8'h00;
      e_valid = 1'b0; e_ack = 1'b0;
      if (m_mode == 0) begin
         e_addr = RST_VEC;
      end else if (m_mode == 2) begin
         e_addr = INT_VEC;
         e_ack  = 1'b1;
      end else begin
         enter   = !redirect_valid && int_req && !stall;
         e_addr  = m_pc;
         e_pc    = m_pc;
         e_pc1   = 8'((int'(m_pc) + 1) % 256);
         e_valid = !enter;
         e_instr = enter ? NOP : imem[m_pc];
      end
      check("imem_addr", imem_addr, e_addr);
      check("if_instruction", if_instruction, e_instr);
      check("if_valid", if_valid, e_valid);
      check("int_ack", int_ack, e_ack);
      check("int_return_pc", int_return_pc, m_saved);
      if (m_mode == 1) begin
         check("if_pc", if_pc, e_pc);
         check("if_pc_plus_1", if_pc_plus_1, e_pc1);
      end
   endtask

   task automatic model_edge();
      if (m_mode == 0) begin
         m_pc   = imem[RST_VEC];
         m_mode = 1;
      end else if (m_mode == 2) begin
         m_pc   = imem[INT_VEC];
         m_mode = 1;
      end else if (redirect_valid) begin
         m_pc = redirect_target;
      end else if (int_req && !stall) begin
         m_saved = m_pc;
         m_mode  = 2;
      end else if (!stall) begin
         m_pc = 8'((int'(m_pc) + 1) % 256);
      end
   endtask

   // Advance one clock, then apply this cycle's inputs and check the outputs.
   task automatic cycle(input bit s, input bit rv, input logic [7:0] rt, input bit ir);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      stall = s; redirect_valid = rv; redirect_target = rt; int_req = ir;
      #1;
      check_model();
   endtask

   // Asserts rst immediately (async), checks reset values, then releases on a negedge.
   task automatic do_reset();
      rst = 1'b1;
      stall = 1'b0; redirect_valid = 1'b0; redirect_target = 8'h00; int_req = 1'b0;
      #1;
      m_mode = 0; m_pc = 8'h00; m_saved = 8'h00;
      check("rst_if_valid", if_valid, 1'b0);
      check("rst_int_ack", int_ack, 1'b0);
      check("rst_if_instruction", if_instruction, NOP);
      check("rst_if_pc", if_pc, 8'h00);
      check("rst_if_pc_plus_1", if_pc_plus_1, 8'h00);
      check("rst_int_return_pc", int_return_pc, 8'h00);
      @(posedge clk);
      @(negedge clk);
      check("rst_held_if_valid", if_valid, 1'b0);
      rst = 1'b0;
      #1;
      check_model();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
      imem[8'h00] = 8'h20;
      imem[8'h01] = 8'h80;
      imem[8'h20] = 8'hAA;

      // Boot
      #2;
      do_reset();
      check("boot_addr", imem_addr, RST_VEC);
      cycle(0, 0, 8'h00, 0);
      check("boot_if_pc", if_pc, 8'h20);
      check("boot_instr", if_instruction, 8'hAA);
      check("boot_pc_plus_1", if_pc_plus_1, 8'h21);

      // Stall at 0x22 for three cycles
      cycle(0, 0, 8'h00, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, 8'h00, 0);
         check("stall_if_pc", if_pc, 8'h22);
         check("stall_addr", imem_addr, 8'h22);
      end
      cycle(0, 0, 8'h00, 0);
      cycle(0, 0, 8'h00, 0);
      check("stall_release", if_pc, 8'h23);

      // Interrupt at 0x25
      cycle(0, 0, 8'h00, 0);
      cycle(0, 0, 8'h00, 1);
      check("int_entry_pc", if_pc, 8'h25);
      check("int_entry_valid", if_valid, 1'b0);
      cycle(0, 0, 8'h00, 0);
      check("int_ack_pulse", int_ack, 1'b1);
      check("int_return", int_return_pc, 8'h25);
      cycle(0, 0, 8'h00, 0);
      check("handler_pc", if_pc, 8'h80);
      check("int_ack_clear", int_ack, 1'b0);

      // Redirect wins over stall and interrupt
      cycle(1, 1, 8'h40, 1);
      cycle(0, 0, 8'h00, 0);
      check("redirect_stall", if_pc, 8'h40);

      // Interrupt deferred while stalled
      cycle(1, 0, 8'h00, 1);
      cycle(1, 0, 8'h00, 1);
      check("int_deferred_valid", if_valid, 1'b1);
      check("int_deferred_pc", if_pc, 8'h41);
      cycle(0, 0, 8'h00, 1);
      check("int_after_stall", if_valid, 1'b0);
      cycle(0, 0, 8'h00, 0);
      check("int2_return", int_return_pc, 8'h41);
      cycle(0, 0, 8'h00, 0);

      // Wrap at 0xFF
      cycle(0, 1, 8'hFE, 0);
      cycle(0, 0, 8'h00, 0);
      cycle(0, 0, 8'h00, 0);
      check("wrap_ff", if_pc, 8'hFF);
      check("wrap_plus_1", if_pc_plus_1, 8'h00);
      cycle(0, 0, 8'h00, 0);
      check("wrap_zero", if_pc, 8'h00);

      // Reset while loading the handler vector
      cycle(0, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 0);
      check("pre_rst_ack", int_ack, 1'b1);
      do_reset();
      cycle(0, 0, 8'h00, 0);
      check("reboot_if_pc", if_pc, 8'h20);

      // Randomized control traffic
      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
               8'($urandom), $urandom_range(0, 9) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not complete");
   end

endmodule
